// File: rtl/addsub_pkg.sv
// Shared constants for the registered adder/subtracter datapath leaf.
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 32;
    localparam int ADDSUB_MSB   = ADDSUB_WIDTH - 1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : addsub_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell; the ripple chain in adder_subtracter_32 is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/adder_subtracter_32.sv
// Registered two's-complement adder/subtracter with signed-overflow flag, one-cycle latency.
// Define ADDSUB_CARRY_OUT_EN to add the registered carry-out port c_out.
module adder_subtracter_32
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
`ifdef ADDSUB_CARRY_OUT_EN
    output logic             c_out,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic             v
);

    if (WIDTH < 2) begin : g_width_check
        $error("adder_subtracter_32: WIDTH must be at least 2");
    end

    // Handshake: valid-only, no ready. in_valid qualifies x/y/c_in in the cycle it is high;
    // the matching result is presented with out_valid exactly one cycle later, every cycle.
    logic [WIDTH-1:0] ye;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             ov;

    assign ye   = y ^ {WIDTH{c_in == OP_SUB}};
    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (x[i]),
            .b    (ye[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Overflow when the carries into and out of the sign cell disagree.
    assign ov = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r         <= '0;
            v         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r <= s;
                v <= ov;
            end
        end
    end

`ifdef ADDSUB_CARRY_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_out <= 1'b0;
        end else if (in_valid) begin
            c_out <= c[WIDTH];
        end
    end
`endif

endmodule : adder_subtracter_32

// File: tb/tb_adder_subtracter_32.sv
// Bench for adder_subtracter_32: directed corner vectors plus random traffic against an
// arithmetic reference model, with a mid-stream asynchronous reset.
module tb_adder_subtracter_32;

    localparam int W  = 32;
    localparam int EW = W + 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c_in;
    logic         out_valid;
    logic [W-1:0] r;
    logic         v;
    logic         obs_co;

    int n_tests;
    int n_fail;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] hold_val;
    logic          issued;

    adder_subtracter_32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
`ifdef ADDSUB_CARRY_OUT_EN
        .c_out     (obs_co),
`endif
        .out_valid (out_valid),
        .r         (r),
        .v         (v)
    );

`ifndef ADDSUB_CARRY_OUT_EN
    assign obs_co = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: signed arithmetic on wide integers, result wrapped to W bits.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic op);
        longint sa, sb, res, max_v, min_v;
        logic   ovf, co;
        logic [W-1:0] rr;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        max_v = (longint'(1) <<< (W - 1)) - 1;
        min_v = -(longint'(1) <<< (W - 1));
        res   = op ? (sa - sb) : (sa + sb);
        ovf   = (res > max_v) || (res < min_v);
        rr    = res[W-1:0];
`ifdef ADDSUB_CARRY_OUT_EN
        if (op) co = (a >= b);
        else    co = ((longint'(a) + longint'(b)) >= (longint'(1) <<< W));
`else
        co = 1'b0;
`endif
        return {co, ovf, rr};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(posedge clk) issued = rst_n && in_valid;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            hold_val = '0;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_result", 64'({obs_co, v, r}), 64'd0);
        end else if (issued) begin
            check("out_valid_hi", 64'(out_valid), 64'd1);
            check("exp_q_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", 64'({obs_co, v, r}), 64'(e));
                hold_val = e;
            end
        end else begin
            check("out_valid_lo", 64'(out_valid), 64'd0);
            check("hold", 64'({obs_co, v, r}), 64'(hold_val));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        @(negedge clk);
        x        = a;
        y        = b;
        c_in     = op;
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, op));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            x        = $urandom;
            y        = $urandom;
            c_in     = 1'($urandom_range(0, 1));
        end
    endtask

    // Asserts reset between edges and confirms outputs clear without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_r", 64'(r), 64'd0);
        check("async_rst_v", 64'(v), 64'd0);
        check("async_rst_co", 64'(obs_co), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] corner(input int k);
        case (k)
            0:       return '0;
            1:       return {{(W-1){1'b0}}, 1'b1};
            2:       return '1;
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        hold_val = '0;
        issued   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        c_in     = 1'b0;
        idle(2);
        #1;
        rst_n = 1'b1;
        idle(1);

        drive(32'h0000_0004, 32'h0000_0001, 1'b0);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drive(32'h0000_0100, 32'hFFFF_FE00, 1'b0);
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b1);
        drive(32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1);
        drive(32'h0000_0000, 32'h0000_0000, 1'b1);
        idle(2);
        drive(32'h8000_0000, 32'h0000_0001, 1'b1);
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        drive(32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        drive(32'hFFFF_FFFD, 32'h0000_0001, 1'b1);
        drive(32'h0000_0000, 32'h0000_0000, 1'b0);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        drive(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        idle(3);

        // In-flight transaction is discarded by the reset.
        drive(32'h1234_5678, 32'h0101_0101, 1'b0);
        async_reset();
        idle(1);
        drive(32'h0000_0002, 32'h0000_0003, 1'b1);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            if ($urandom_range(0, 3) != 0)
                drive(corner($urandom_range(0, 9)), corner($urandom_range(0, 9)),
                      1'($urandom_range(0, 1)));
            else
                idle(1);
        end
        idle(3);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder_subtracter_32
